// File: rtl/mipi_pkg.sv
// -----------------------------------------------------------------------------
// mipi_pkg
// Shared types and constants for the D-PHY data-lane transmit sequencer.
//   mipi_seq_st_t : sequencer state encoding
//   SYNC_BYTE     : HS leader byte sent on every lane before the payload
//   LP11/LP01/LP00: low-power line codes, packed as {dp, dn}
// -----------------------------------------------------------------------------
package mipi_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LPX     = 3'd1,
        PREP    = 3'd2,
        HS_ZERO = 3'd3,
        SYNC    = 3'd4,
        DATA    = 3'd5,
        TRAIL   = 3'd6,
        EXIT    = 3'd7
    } mipi_seq_st_t;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

    localparam logic [1:0] LP11 = 2'b11;
    localparam logic [1:0] LP01 = 2'b01;
    localparam logic [1:0] LP00 = 2'b00;

endpackage

// File: rtl/mipi_tim_cnt.sv
// -----------------------------------------------------------------------------
// mipi_tim_cnt
// Loadable down-counter used to time the LP/HS phases of the sequencer.
// A load takes priority; otherwise the count decrements and parks at zero.
//   i_clk      : byte clock
//   i_rst_n    : asynchronous active-low reset (count cleared)
//   i_load     : load i_load_val this cycle
//   i_load_val : value loaded (phase length minus one)
//   o_zero     : count is zero
// -----------------------------------------------------------------------------
module mipi_tim_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    // Phase timer: load on state entry, then count down to zero and hold.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != {CNT_W{1'b0}}) begin
            r_cnt <= r_cnt - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_zero = (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/mipi_dphy_tx_seq.sv
// -----------------------------------------------------------------------------
// mipi_dphy_tx_seq
// D-PHY data-lane transmit sequencer. Per packet it walks the lanes through
// LP-11 -> LP-01 -> LP-00 -> HS-zero -> sync -> payload -> trail -> LP-11,
// taking payload byte groups over a valid/ready stream.
//   clk, resetn        : byte clock, asynchronous active-low reset
//   s_valid/s_data/
//   s_last/s_ready     : payload stream, one byte per lane per beat
//   lp_dp, lp_dn       : LP line levels shared by all data lanes
//   hs_en, hs_data     : HS driver enable and per-lane HS byte (lane i = [8i+7:8i])
//   busy               : sequencer not idle
//   underrun           : one-cycle pulse when a packet is aborted for lack of data
// -----------------------------------------------------------------------------
module mipi_dphy_tx_seq
    import mipi_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int T_LPX   = 4,
    parameter int T_PREP  = 2,
    parameter int T_ZERO  = 6,
    parameter int T_TRAIL = 4,
    parameter int T_EXIT  = 6,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               s_valid,
    input  logic [8*LANES-1:0] s_data,
    input  logic               s_last,
    output logic               s_ready,
    output logic               lp_dp,
    output logic               lp_dn,
    output logic               hs_en,
    output logic [8*LANES-1:0] hs_data,
    output logic               busy,
    output logic               underrun
);

    localparam int T_MAX = (1 << CNT_W);

    if (LANES < 1 || LANES > 4) begin : g_bad_lanes
        $error("mipi_dphy_tx_seq: LANES must be in 1..4");
    end
    if (T_LPX < 1 || T_PREP < 1 || T_ZERO < 1 || T_TRAIL < 1 || T_EXIT < 1) begin : g_bad_tmin
        $error("mipi_dphy_tx_seq: every T_* must be at least 1");
    end
    if (T_LPX >= T_MAX || T_PREP >= T_MAX || T_ZERO >= T_MAX ||
        T_TRAIL >= T_MAX || T_EXIT >= T_MAX) begin : g_bad_tmax
        $error("mipi_dphy_tx_seq: every T_* must fit in CNT_W bits");
    end

    mipi_seq_st_t       r_state;
    logic [1:0]         r_lp;
    logic               r_hs_en;
    logic [8*LANES-1:0] r_hs_data;
    logic               r_last_q;
    logic               r_underrun;

    logic               w_hs;
    logic               w_zero;
    logic               w_load;
    logic [CNT_W-1:0]   w_load_val;
    logic [8*LANES-1:0] w_trail;

    // Ready is decoded from registers so it never depends on s_valid.
    assign s_ready = (r_state == SYNC) | ((r_state == DATA) & ~r_last_q);
    assign w_hs    = s_valid & s_ready;

    // Trail level per lane is the inverse of the last HS bit sent (MSB goes out last).
    always_comb begin
        w_trail = {(8*LANES){1'b0}};
        for (int i = 0; i < LANES; i++) begin
            w_trail[8*i +: 8] = {8{~r_hs_data[8*i+7]}};
        end
    end

    // Timer reload on entry to each timed state; mirrors the FSM transitions below.
    always_comb begin
        w_load     = 1'b0;
        w_load_val = {CNT_W{1'b0}};
        case (r_state)
            IDLE: begin
                if (s_valid) begin
                    w_load     = 1'b1;
                    w_load_val = CNT_W'(T_LPX - 1);
                end else begin
                    w_load     = 1'b0;
                end
            end
            LPX: begin
                if (w_zero) begin
                    w_load     = 1'b1;
                    w_load_val = CNT_W'(T_PREP - 1);
                end else begin
                    w_load     = 1'b0;
                end
            end
            PREP: begin
                if (w_zero) begin
                    w_load     = 1'b1;
                    w_load_val = CNT_W'(T_ZERO - 1);
                end else begin
                    w_load     = 1'b0;
                end
            end
            SYNC: begin
                if (!w_hs) begin
                    w_load     = 1'b1;
                    w_load_val = CNT_W'(T_TRAIL - 1);
                end else begin
                    w_load     = 1'b0;
                end
            end
            DATA: begin
                if (r_last_q || !s_valid) begin
                    w_load     = 1'b1;
                    w_load_val = CNT_W'(T_TRAIL - 1);
                end else begin
                    w_load     = 1'b0;
                end
            end
            TRAIL: begin
                if (w_zero) begin
                    w_load     = 1'b1;
                    w_load_val = CNT_W'(T_EXIT - 1);
                end else begin
                    w_load     = 1'b0;
                end
            end
            default: begin
                w_load     = 1'b0;
                w_load_val = {CNT_W{1'b0}};
            end
        endcase
    end

    mipi_tim_cnt #(
        .CNT_W(CNT_W)
    ) u_tim_cnt (
        .i_clk     (clk),
        .i_rst_n   (resetn),
        .i_load    (w_load),
        .i_load_val(w_load_val),
        .o_zero    (w_zero)
    );

    // Sequencer FSM; outputs are registered with the values of the state being entered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= IDLE;
            r_lp       <= LP11;
            r_hs_en    <= 1'b0;
            r_hs_data  <= {(8*LANES){1'b0}};
            r_last_q   <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_underrun <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (s_valid) begin
                        r_state <= LPX;
                        r_lp    <= LP01;
                    end
                end
                LPX: begin
                    if (w_zero) begin
                        r_state <= PREP;
                        r_lp    <= LP00;
                    end
                end
                PREP: begin
                    if (w_zero) begin
                        r_state   <= HS_ZERO;
                        r_hs_en   <= 1'b1;
                        r_hs_data <= {(8*LANES){1'b0}};
                    end
                end
                HS_ZERO: begin
                    if (w_zero) begin
                        r_state   <= SYNC;
                        r_hs_data <= {LANES{SYNC_BYTE}};
                    end
                end
                SYNC: begin
                    if (w_hs) begin
                        r_state   <= DATA;
                        r_hs_data <= s_data;
                        r_last_q  <= s_last;
                    end else begin
                        r_state    <= TRAIL;
                        r_hs_data  <= w_trail;
                        r_underrun <= 1'b1;
                    end
                end
                DATA: begin
                    if (r_last_q) begin
                        // Last byte has been on the bus for one cycle; close the burst.
                        r_state   <= TRAIL;
                        r_hs_data <= w_trail;
                        r_last_q  <= 1'b0;
                    end else if (w_hs) begin
                        r_hs_data <= s_data;
                        r_last_q  <= s_last;
                    end else begin
                        r_state    <= TRAIL;
                        r_hs_data  <= w_trail;
                        r_underrun <= 1'b1;
                    end
                end
                TRAIL: begin
                    if (w_zero) begin
                        r_state   <= EXIT;
                        r_lp      <= LP11;
                        r_hs_en   <= 1'b0;
                        r_hs_data <= {(8*LANES){1'b0}};
                    end
                end
                EXIT: begin
                    if (w_zero) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_lp      <= LP11;
                    r_hs_en   <= 1'b0;
                    r_hs_data <= {(8*LANES){1'b0}};
                    r_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign lp_dp    = r_lp[1];
    assign lp_dn    = r_lp[0];
    assign hs_en    = r_hs_en;
    assign hs_data  = r_hs_data;
    assign busy     = (r_state != IDLE);
    assign underrun = r_underrun;

endmodule

// File: tb/tb_mipi_dphy_tx_seq.sv
// -----------------------------------------------------------------------------
// tb_mipi_dphy_tx_seq
// Directed bench for mipi_dphy_tx_seq: a per-cycle vector table for whole
// packets on a 4-lane instance, plus hand-written reset and 1-lane sequences.
// -----------------------------------------------------------------------------
module tb_mipi_dphy_tx_seq;

    logic        clk = 1'b0;
    logic        resetn;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_last;
    logic        s_ready;
    logic        lp_dp;
    logic        lp_dn;
    logic        hs_en;
    logic [31:0] hs_data;
    logic        busy;
    logic        underrun;

    logic        v1;
    logic [7:0]  d1;
    logic        l1;
    logic        rdy1;
    logic        dp1;
    logic        dn1;
    logic        en1;
    logic [7:0]  hd1;
    logic        busy1;
    logic        un1;

    always #5 clk = ~clk;

    mipi_dphy_tx_seq #(.LANES(4)) u_dut (
        .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
        .s_ready(s_ready), .lp_dp(lp_dp), .lp_dn(lp_dn), .hs_en(hs_en), .hs_data(hs_data),
        .busy(busy), .underrun(underrun)
    );

    mipi_dphy_tx_seq #(.LANES(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .s_valid(v1), .s_data(d1), .s_last(l1),
        .s_ready(rdy1), .lp_dp(dp1), .lp_dn(dn1), .hs_en(en1), .hs_data(hd1),
        .busy(busy1), .underrun(un1)
    );

    typedef struct {
        string       tag;
        logic        v;
        logic [31:0] d;
        logic        l;
        logic [37:0] exp;
    } row_t;

    row_t rows[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   hs_cnt = 0;

    always @(posedge clk) begin
        if (resetn && s_valid && s_ready) hs_cnt <= hs_cnt + 1;
    end

    // Expected observation word: {lp_dp, lp_dn, hs_en, s_ready, busy, underrun, hs_data}
    function automatic logic [37:0] ex(input logic [1:0] lp, input logic hen, input logic rdy,
                                       input logic bsy, input logic un, input logic [31:0] hd);
        return {lp, hen, rdy, bsy, un, hd};
    endfunction

    function automatic logic [37:0] obs();
        return {lp_dp, lp_dn, hs_en, s_ready, busy, underrun, hs_data};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, expv);
    endtask

    function automatic void add(input string t, input logic v, input logic [31:0] d,
                                input logic l, input logic [37:0] e);
        row_t r;
        r.tag = t; r.v = v; r.d = d; r.l = l; r.exp = e;
        rows.push_back(r);
    endfunction

    function automatic void add_idle(input string t, input logic v);
        add(t, v, 32'h0, 1'b0, ex(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0));
    endfunction

    // LPX x4, PREP x2, HS_ZERO x6 with s_valid held
    function automatic void add_body(input string t);
        for (int i = 0; i < 4; i++) add(t, 1'b1, 32'h0, 1'b0, ex(2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
        for (int i = 0; i < 2; i++) add(t, 1'b1, 32'h0, 1'b0, ex(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
        for (int i = 0; i < 6; i++) add(t, 1'b1, 32'h0, 1'b0, ex(2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0));
    endfunction

    function automatic void add_sync(input string t, input logic v, input logic [31:0] d, input logic l);
        add(t, v, d, l, ex(2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 32'hB8B8B8B8));
    endfunction

    function automatic void add_data(input string t, input logic v, input logic [31:0] d, input logic l,
                                     input logic rdy, input logic [31:0] hd);
        add(t, v, d, l, ex(2'b00, 1'b1, rdy, 1'b1, 1'b0, hd));
    endfunction

    function automatic void add_trail(input string t, input logic v, input logic [31:0] hd, input logic un);
        for (int i = 0; i < 4; i++)
            add(t, v, 32'h0, 1'b0, ex(2'b00, 1'b1, 1'b0, 1'b1, (i == 0) ? un : 1'b0, hd));
    endfunction

    function automatic void add_exit(input string t, input logic v);
        for (int i = 0; i < 6; i++) add(t, v, 32'h0, 1'b0, ex(2'b11, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0));
    endfunction

    // Called just after a rising edge; checks each row at the following falling edge.
    task automatic run_rows(input int a, input int b);
        for (int i = a; i < b; i++) begin
            s_valid = rows[i].v;
            s_data  = rows[i].d;
            s_last  = rows[i].l;
            @(negedge clk);
            chk($sformatf("%s[%0d]", rows[i].tag, i), {26'h0, obs()}, {26'h0, rows[i].exp});
            @(posedge clk);
            #1;
        end
    endtask

    int s1_end, su_end, ss_end, s5_end, snap, cyc;

    initial begin
        resetn = 1'b0; s_valid = 1'b0; s_data = 32'h0; s_last = 1'b0;
        v1 = 1'b0; d1 = 8'h0; l1 = 1'b0;

        // 3-beat packet; last beat 80_00_80_01 gives trail FF/00/FF/00 on lanes 0..3
        add_idle("pkt3", 1'b1); add_body("pkt3");
        add_sync("pkt3", 1'b1, 32'h11223344, 1'b0);
        add_data("pkt3", 1'b1, 32'h55667788, 1'b0, 1'b1, 32'h11223344);
        add_data("pkt3", 1'b1, 32'h80008001, 1'b1, 1'b1, 32'h55667788);
        add_data("pkt3", 1'b0, 32'h0, 1'b0, 1'b0, 32'h80008001);
        add_trail("pkt3", 1'b0, 32'h00FF00FF, 1'b0);
        add_exit("pkt3", 1'b0);
        add_idle("pkt3", 1'b0); add_idle("pkt3", 1'b0);
        s1_end = rows.size();

        // valid dropped mid-DATA: underrun, trail of 7F80FF01, no ready afterwards
        add_idle("undr", 1'b1); add_body("undr");
        add_sync("undr", 1'b1, 32'hA0A0A0A0, 1'b0);
        add_data("undr", 1'b1, 32'h7F80FF01, 1'b0, 1'b1, 32'hA0A0A0A0);
        add_data("undr", 1'b0, 32'h0, 1'b0, 1'b1, 32'h7F80FF01);
        add_trail("undr", 1'b1, 32'hFF0000FF, 1'b1);
        add_exit("undr", 1'b1);
        add_idle("undr", 1'b0); add_idle("undr", 1'b0);
        su_end = rows.size();

        // no handshake in SYNC: trail of B8 is all-zero, underrun
        add_idle("syncu", 1'b1); add_body("syncu");
        add_sync("syncu", 1'b0, 32'h0, 1'b0);
        add_trail("syncu", 1'b0, 32'h00000000, 1'b1);
        add_exit("syncu", 1'b0);
        add_idle("syncu", 1'b0);
        ss_end = rows.size();

        // back-to-back: valid held through EXIT, IDLE lasts one cycle
        add_idle("b2b", 1'b1); add_body("b2b");
        add_sync("b2b", 1'b1, 32'hCAFEF00D, 1'b0);
        add_data("b2b", 1'b1, 32'h00FF7F80, 1'b1, 1'b1, 32'hCAFEF00D);
        add_data("b2b", 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h00FF7F80);
        add_trail("b2b", 1'b1, 32'hFF00FF00, 1'b0);
        add_exit("b2b", 1'b1);
        add_idle("b2b", 1'b1); add_body("b2b");
        add_sync("b2b", 1'b1, 32'h12345678, 1'b1);
        add_data("b2b", 1'b0, 32'h0, 1'b0, 1'b0, 32'h12345678);
        add_trail("b2b", 1'b0, 32'hFFFFFFFF, 1'b0);
        add_exit("b2b", 1'b0);
        add_idle("b2b", 1'b0);
        s5_end = rows.size();

        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {26'h0, obs()}, {26'h0, ex(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0)});
        chk("reset_state_l1", {54'h0, en1, rdy1, busy1, un1, dp1, dn1, 1'b0, 1'b0, hd1},
            {54'h0, 8'b0000_1100, 8'h00});
        resetn = 1'b1;

        run_rows(0, s1_end);
        run_rows(s1_end, su_end);
        run_rows(su_end, ss_end);
        snap = hs_cnt;
        run_rows(ss_end, s5_end);
        chk("b2b_beats_in", 64'(hs_cnt - snap), 64'd3);

        // reset during HS_ZERO
        s_valid = 1'b1;
        repeat (9) begin @(posedge clk); #1; end
        chk("rst_pre_hszero", {61'h0, hs_en, lp_dp, lp_dn}, {61'h0, 3'b100});
        #2 resetn = 1'b0;
        #1 chk("rst_in_hszero", {26'h0, obs()}, {26'h0, ex(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0)});
        s_valid = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;

        // reset during DATA
        s_valid = 1'b1;
        repeat (13) begin @(posedge clk); #1; end
        chk("rst_sync_latency", {31'h0, s_ready, hs_data}, {31'h0, 1'b1, 32'hB8B8B8B8});
        s_data = 32'h0A0B0C0D;
        @(posedge clk); #1;
        chk("rst_pre_data", {31'h0, s_ready, hs_data}, {31'h0, 1'b1, 32'h0A0B0C0D});
        #2 resetn = 1'b0;
        #1 chk("rst_in_data", {26'h0, obs()}, {26'h0, ex(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0)});
        s_valid = 1'b0; s_data = 32'h0;
        @(posedge clk); #1;
        resetn = 1'b1;

        // clean restart
        run_rows(0, s1_end);

        // 1-lane, 1-beat packet
        v1 = 1'b1; d1 = 8'h85; l1 = 1'b1; cyc = 0;
        while (!rdy1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("l1_sync_latency", {63'h0, rdy1}, 64'd1);
        chk("l1_sync_cycles", 64'(cyc), 64'd13);
        @(posedge clk); #1;
        v1 = 1'b0; l1 = 1'b0;
        chk("l1_data", {53'h0, en1, rdy1, un1, hd1}, {53'h0, 3'b100, 8'h85});
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("l1_trail%0d", i), {51'h0, en1, rdy1, un1, dp1, dn1, hd1},
                {51'h0, 5'b10000, 8'h00});
        end
        @(posedge clk); #1;
        chk("l1_exit", {60'h0, en1, dp1, dn1, busy1}, {60'h0, 4'b0111});

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
